// File: rtl/mem_wb_stage_pkg.sv
// Shared types for the MEM/WB stage: memory-op codes, FSM encoding and lane helpers.
package mem_wb_stage_pkg;

  localparam int RegAddrBus = 5;
  localparam int RegDataBus = 32;

  typedef logic [3:0] byte_sel_t;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LBU  = 4'd2,
    MEM_LH   = 4'd3,
    MEM_LHU  = 4'd4,
    MEM_LW   = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } memop_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MEM  = 1'b1
  } state_e;

  function automatic logic is_load(memop_e op);
    return op inside {MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW};
  endfunction

  function automatic logic is_store(memop_e op);
    return op inside {MEM_SB, MEM_SH, MEM_SW};
  endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// EX/MEM input, data-memory port and register-file write port of the MEM/WB stage.
interface mem_wb_stage_if;
  import mem_wb_stage_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic                  in_we;
  logic [RegAddrBus-1:0] in_waddr;
  logic [RegDataBus-1:0] in_alu;
  logic [3:0]            in_memop;
  logic [RegDataBus-1:0] in_sdata;

  logic                  dmem_req;
  logic                  dmem_we;
  logic [31:0]           dmem_addr;
  byte_sel_t             dmem_be;
  logic [31:0]           dmem_wdata;
  logic                  dmem_ack;
  logic [31:0]           dmem_rdata;

  logic                  wb_we;
  logic [RegAddrBus-1:0] wb_waddr;
  logic [RegDataBus-1:0] wb_wdata;
  logic                  misalign_exc;

  modport slave (
    input  in_valid, in_we, in_waddr, in_alu, in_memop, in_sdata,
    output in_ready,
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ack, dmem_rdata,
    output wb_we, wb_waddr, wb_wdata, misalign_exc
  );

  modport master (
    output in_valid, in_we, in_waddr, in_alu, in_memop, in_sdata,
    input  in_ready,
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ack, dmem_rdata,
    input  wb_we, wb_waddr, wb_wdata, misalign_exc
  );

endinterface

// File: rtl/mem_wb_stage_mem_align.sv
// Combinational lane logic: byte enables, store replication, load extraction/extension, misalign.
module mem_wb_stage_mem_align
  import mem_wb_stage_pkg::*;
(
  input  memop_e      op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] sdata_i,
  output byte_sel_t   be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ldata_o,
  output logic        misalign_o
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_b = rdata_i[{addr_lo_i, 3'b000} +: 8];
  assign lane_h = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    be_o       = 4'b0000;
    wdata_o    = sdata_i;
    ldata_o    = rdata_i;
    misalign_o = 1'b0;
    case (op_i)
      MEM_LB:  begin be_o = 4'b1111; ldata_o = {{24{lane_b[7]}}, lane_b}; end
      MEM_LBU: begin be_o = 4'b1111; ldata_o = {24'h0, lane_b}; end
      MEM_LH:  begin
        be_o = 4'b1111; ldata_o = {{16{lane_h[15]}}, lane_h}; misalign_o = addr_lo_i[0];
      end
      MEM_LHU: begin
        be_o = 4'b1111; ldata_o = {16'h0, lane_h}; misalign_o = addr_lo_i[0];
      end
      MEM_LW:  begin be_o = 4'b1111; misalign_o = (addr_lo_i != 2'b00); end
      MEM_SB:  begin be_o = 4'b0001 << addr_lo_i; wdata_o = {4{sdata_i[7:0]}}; end
      MEM_SH:  begin
        be_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{sdata_i[15:0]}};
        misalign_o = addr_lo_i[0];
      end
      MEM_SW:  begin be_o = 4'b1111; misalign_o = (addr_lo_i != 2'b00); end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB stage FSM. IDLE: accepting, in_ready=1 | MEM: request held until dmem_ack.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  mem_wb_stage_if.slave   bus
);

  state_e                state_q;
  memop_e                op_q;
  logic [1:0]            addr_lo_q;
  logic                  we_q;
  logic [RegAddrBus-1:0] waddr_q;
  logic                  dmem_req_q;
  logic                  dmem_we_q;
  logic [31:0]           dmem_addr_q;
  byte_sel_t             dmem_be_q;
  logic [31:0]           dmem_wdata_q;
  logic                  wb_we_q;
  logic [RegAddrBus-1:0] wb_waddr_q;
  logic [RegDataBus-1:0] wb_wdata_q;
  logic                  misalign_q;

  memop_e      req_op;
  memop_e      al_op;
  logic [1:0]  al_addr_lo;
  byte_sel_t   al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_ldata;
  logic        al_misalign;

  assign req_op = memop_e'(bus.in_memop);

  // One aligner serves the request side in IDLE and the response side in MEM.
  assign al_op      = (state_q == ST_MEM) ? op_q : req_op;
  assign al_addr_lo = (state_q == ST_MEM) ? addr_lo_q : bus.in_alu[1:0];

  mem_wb_stage_mem_align u_align (
    .op_i       (al_op),
    .addr_lo_i  (al_addr_lo),
    .rdata_i    (bus.dmem_rdata),
    .sdata_i    (bus.in_sdata),
    .be_o       (al_be),
    .wdata_o    (al_wdata),
    .ldata_o    (al_ldata),
    .misalign_o (al_misalign)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      op_q         <= MEM_NONE;
      addr_lo_q    <= 2'b00;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_be_q    <= '0;
      dmem_wdata_q <= '0;
      wb_we_q      <= 1'b0;
      wb_waddr_q   <= '0;
      wb_wdata_q   <= '0;
      misalign_q   <= 1'b0;
    end else begin
      wb_we_q    <= 1'b0;
      misalign_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            if (!is_load(req_op) && !is_store(req_op)) begin
              wb_we_q    <= bus.in_we;
              wb_waddr_q <= bus.in_waddr;
              wb_wdata_q <= bus.in_alu;
            end else if (al_misalign) begin
              misalign_q <= 1'b1;
            end else begin
              state_q      <= ST_MEM;
              op_q         <= req_op;
              addr_lo_q    <= bus.in_alu[1:0];
              we_q         <= bus.in_we;
              waddr_q      <= bus.in_waddr;
              dmem_req_q   <= 1'b1;
              dmem_we_q    <= is_store(req_op);
              dmem_addr_q  <= {bus.in_alu[31:2], 2'b00};
              dmem_be_q    <= al_be;
              dmem_wdata_q <= al_wdata;
            end
          end
        end
        ST_MEM: begin
          if (bus.dmem_ack) begin
            state_q    <= ST_IDLE;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            if (is_load(op_q)) begin
              wb_we_q    <= we_q;
              wb_waddr_q <= waddr_q;
              wb_wdata_q <= al_ldata;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready     = (state_q == ST_IDLE);
  assign bus.dmem_req     = dmem_req_q;
  assign bus.dmem_we      = dmem_we_q;
  assign bus.dmem_addr    = dmem_addr_q;
  assign bus.dmem_be      = dmem_be_q;
  assign bus.dmem_wdata   = dmem_wdata_q;
  assign bus.wb_we        = wb_we_q;
  assign bus.wb_waddr     = wb_waddr_q;
  assign bus.wb_wdata     = wb_wdata_q;
  assign bus.misalign_exc = misalign_q;

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access and write-back stage directly upstream of the register file. It takes one instruction per handshake from the EX/MEM boundary and performs the data-memory access for loads and stores. It holds the pipeline through variable-latency memory acknowledgements, aligns and extends load data, and drives the registered single-cycle write port (`wb_we`/`wb_waddr`/`wb_wdata`) that feeds the register file's `we`/`waddr`/`wdata`.

## Interface
- Parameters: none; widths come from `defines.vh` (`RegAddrBus` 5 bits, `RegDataBus` 32 bits).
- `clk` in 1: sole clock; all state updates on its rising edge.
- `rst` in 1: asynchronous reset, active-high.
- `in_valid` in 1: an EX/MEM instruction is presented.
- `in_ready` out 1: the stage accepts it this cycle; upstream stalls while low.
- `in_we` in 1: the instruction writes a register.
- `in_waddr` in 5: destination register.
- `in_alu` in 32: ALU result; this is the byte address for memory ops.
- `in_memop` in 4: NONE, LB, LBU, LH, LHU, LW, SB, SH, SW (codes in `defines.vh`).
- `in_sdata` in 32: store data (rt value).
- `dmem_req` out 1: memory request; held until the ack.
- `dmem_we` out 1: the request is a store.
- `dmem_addr` out 32: word address, `{in_alu[31:2],2'b00}`.
- `dmem_be` out 4: byte enables.
- `dmem_wdata` out 32: store data with lanes replicated.
- `dmem_ack` in 1: access complete; `dmem_rdata` is valid in the same cycle.
- `dmem_rdata` in 32: load word.
- `wb_we` out 1: register write strobe to the register file.
- `wb_waddr` out 5: register write address.
- `wb_wdata` out 32: register write data.
- `misalign_exc` out 1: one-cycle pulse on a misaligned access.

## Operation
- Byte order is little-endian: byte k is `rdata[8k+7:8k]`, where k = `addr[1:0]`.
- FSM states:
  - IDLE: `in_ready`=1.
  - MEM: `in_ready`=0, `dmem_req`=1.
- IDLE with `in_valid`:
  - NONE: latch the write-back fields; they appear on the wb outputs next cycle; stay in IDLE.
  - Aligned memory op: latch address, byte enables, store data, op, waddr and we; go to MEM.
  - Misaligned op (halfword with `addr[0]`=1, word with `addr[1:0]`≠0): no request, no write-back; `misalign_exc`=1 next cycle; stay in IDLE.
- MEM: `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_be`, `dmem_wdata` are registered and stable until the ack cycle inclusive. On `dmem_ack`, go to IDLE.
  - Load: aligned data is registered onto the wb outputs with `wb_we`=`in_we` latched.
  - Store: `wb_we`=0.
- Byte enables:
  - SB: `1<<addr[1:0]`.
  - SH: `0011` if `addr[1]`=0, else `1100`.
  - SW: `1111`.
  - Loads: `1111`.
- `dmem_wdata`: SB = `{4{sdata[7:0]}}`; SH = `{2{sdata[15:0]}}`; SW = `sdata`.
- Load extension:
  - LB/LH: sign-extend the selected byte or half.
  - LBU/LHU: zero-extend.
  - LW: full word.
- `wb_we` is a one-cycle pulse per retiring instruction, passed through even when `wb_waddr`=0 (the register file discards writes to r0).
- `dmem_ack` seen while in IDLE is ignored.

## Timing
- Reset (asynchronous): state IDLE.
  - `dmem_req`, `dmem_we`, `wb_we`, `misalign_exc` = 0.
  - `dmem_addr`, `dmem_be`, `dmem_wdata`, `wb_waddr`, `wb_wdata` = 0.
  - A reset during MEM abandons the access and drops `dmem_req` immediately.
- Non-memory op: accept at edge N; `wb_we` high N+1 to N+2 only.
- Memory op: accept at edge N; `dmem_req` high from N+1.
  - Ack sampled at edge N+k: load `wb_we` high for the cycle after N+k.
  - `in_ready` returns high after edge N+k; the next instruction is accepted at edge N+k+1 at the earliest.
  - Minimum memory-op occupancy is 2 cycles: `dmem_ack` is never seen in the same cycle the request is issued, because the request starts at N+1.
- Back-to-back non-memory ops retire one per cycle.
- `in_valid` low while in IDLE: wb outputs hold their data, `wb_we`=0.

## Structure
- `defines.vh` gains:
  - the `in_memop` codes (NONE=0, LB, LBU, LH, LHU, LW, SB, SH, SW);
  - the state encoding (IDLE=0, MEM=1);
  - `ByteSel` (4-bit).
- One sub-module, `mem_align`: purely combinational.
  - Inputs: op, addr[1:0], rdata, sdata.
  - Outputs: be, wdata lanes, extended load value, misalign flag.
  - Used for both the request side and the ack side.

## Test plan
- NONE, `in_alu`=0x12345678, waddr=3, we=1 -> next cycle `wb_we`=1, `wb_waddr`=3, `wb_wdata`=0x12345678; then `wb_we`=0.
- LB at addr 0x1003; memory acks after 3 cycles with rdata 0x80FF0011 -> `dmem_addr`=0x1000, `dmem_be`=1111, `wb_wdata`=0xFFFFFF80; `in_ready` low throughout.
- LHU at addr 0x2002; rdata 0xBEEF1234 -> `wb_wdata`=0x0000BEEF. LH with the same rdata -> 0xFFFFBEEF.
- SB at addr 0x11, sdata 0x000000AB -> `dmem_be`=0010, `dmem_wdata`=0xABABABAB, `dmem_we`=1; no `wb_we`.
- LW at addr 0x6 -> no `dmem_req`, `misalign_exc` 1-cycle pulse, `wb_we`=0, `in_ready` stays 1.
- `rst` asserted mid-MEM, before the ack -> `dmem_req` drops combinationally, state IDLE; a subsequent late `dmem_ack` produces no write.
